// File: rtl/ysyx_23060184_pkg.sv
// Shared types and constants for the write-back unit.
// The load-timeout limit applies only when YSYX_23060184_WB_TIMEOUT_EN is defined.
package ysyx_23060184_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_COMMIT    = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned WB_TIMEOUT_WIDTH = 16;
  localparam logic [WB_TIMEOUT_WIDTH-1:0] WB_TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/ysyx_23060184_wbu_loadext.sv
// Combinational load extender: selects a byte or halfword from the aligned word
// and sign- or zero-extends it according to funct3.
module ysyx_23060184_LoadExt
  import ysyx_23060184_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Unknown funct3 encodings fall back to a full-word load.
  always_comb begin
    ext = word;
    case (funct3)
      F3_LB:   ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_wbu.sv
// Write-back unit: accepts ALU results or loads from execute, waits for load data,
// and retires one register-file write. YSYX_23060184_WB_TIMEOUT_EN adds a load timeout and wb_err.
module ysyx_23060184_wbu
  import ysyx_23060184_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_result,
  input  logic                  exu_is_load,
  input  logic [2:0]            exu_funct3,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_rd
`ifdef YSYX_23060184_WB_TIMEOUT_EN
  ,
  output logic                  wb_err
`endif
);

  wbu_state_e            state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_q, rd_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [2:0]            f3_q, f3_nxt;
  logic [1:0]            off_q, off_nxt;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  ready_nxt, wen_nxt, done_nxt, pend_nxt;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
  logic [WB_TIMEOUT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                        err_q, err_nxt;
`endif

  ysyx_23060184_LoadExt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_loadext (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (lsu_rdata),
    .ext    (load_ext)
  );

  // Next state, latched payload and the registered outputs derived from the next state.
  always_comb begin
    state_nxt = state_q;
    rd_nxt    = rd_q;
    data_nxt  = data_q;
    f3_nxt    = f3_q;
    off_nxt   = off_q;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (exu_valid && exu_ready) begin
          rd_nxt    = exu_rd;
          data_nxt  = exu_result;
          f3_nxt    = exu_funct3;
          off_nxt   = exu_result[1:0];
          state_nxt = exu_is_load ? ST_WAIT_LOAD : ST_COMMIT;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      ST_WAIT_LOAD: begin
        if (lsu_rvalid) begin
          data_nxt  = load_ext;
          state_nxt = ST_COMMIT;
        end
`ifdef YSYX_23060184_WB_TIMEOUT_EN
        else if (cnt_q == WB_TIMEOUT_LIMIT) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
`endif
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
    done_nxt  = (state_nxt == ST_COMMIT);
    wen_nxt   = (state_nxt == ST_COMMIT) && (rd_nxt != '0);
    pend_nxt  = (state_nxt == ST_WAIT_LOAD) || wen_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      data_q     <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      exu_ready  <= 1'b1;
      rf_wen     <= 1'b0;
      wb_done    <= 1'b0;
      pend_valid <= 1'b0;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      rd_q       <= rd_nxt;
      data_q     <= data_nxt;
      f3_q       <= f3_nxt;
      off_q      <= off_nxt;
      exu_ready  <= ready_nxt;
      rf_wen     <= wen_nxt;
      wb_done    <= done_nxt;
      pend_valid <= pend_nxt;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
      cnt_q      <= cnt_nxt;
      err_q      <= err_nxt;
`endif
    end
  end

  assign rf_waddr = rd_q;
  assign rf_wdata = data_q;
  assign pend_rd  = rd_q;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
  assign wb_err   = err_q;
`endif

endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Scoreboard bench for the write-back unit; the timeout scenario runs when
// YSYX_23060184_WB_TIMEOUT_EN is defined.
module tb_ysyx_23060184_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_result;
  logic        exu_is_load;
  logic [2:0]  exu_funct3;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_done;
  logic        pend_valid;
  logic [4:0]  pend_rd;
`ifdef YSYX_23060184_WB_TIMEOUT_EN
  logic        wb_err;
`endif

  ysyx_23060184_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_result  (exu_result),
    .exu_is_load (exu_is_load),
    .exu_funct3  (exu_funct3),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_done     (wb_done),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd)
`ifdef YSYX_23060184_WB_TIMEOUT_EN
    ,
    .wb_err      (wb_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the addressed byte/halfword by shifting, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] addr,
                                             input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * addr)) & 32'hFF;
    h = (word >> (16 * (addr / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Monitor: every retire pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wb_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wb_done", 32'(wb_done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rf_wen", 32'(rf_wen), 32'(mon_e.wen));
        chk("pend_valid_commit", 32'(pend_valid), 32'(mon_e.wen));
        chk("ready_in_commit", 32'(exu_ready), 32'd0);
        if (mon_e.wen) begin
          chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.rd));
          chk("rf_wdata", rf_wdata, mon_e.data);
          chk("pend_rd_commit", 32'(pend_rd), 32'(mon_e.rd));
        end
      end
    end else if (!rst && rf_wen) begin
      chk("rf_wen_without_done", 32'(rf_wen), 32'd0);
    end
  end

  // Presents one result, holds it until accepted; returns 1 on accept.
  task automatic offer(input logic is_load, input logic [4:0] rd, input logic [31:0] res,
                       input logic [2:0] f3, output logic ok);
    int budget;
    @(posedge clk); #1;
    exu_valid   = 1'b1;
    exu_rd      = rd;
    exu_result  = res;
    exu_is_load = is_load;
    exu_funct3  = f3;
    budget = 0;
    @(negedge clk);
    while (!exu_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    ok = exu_ready;
    if (!ok) chk("accept_timeout", 32'(exu_ready), 32'd1);
    @(posedge clk); #1;
    exu_valid   = 1'b0;
    exu_rd      = 5'($urandom);
    exu_result  = $urandom;
    exu_is_load = 1'($urandom);
    exu_funct3  = 3'($urandom);
  endtask

  task automatic txn(input logic is_load, input logic [4:0] rd, input logic [31:0] res,
                     input logic [2:0] f3, input logic [31:0] rdata, input int delay);
    exp_t e;
    logic ok;
    e.rd   = rd;
    e.wen  = (rd != 5'd0);
    e.data = is_load ? model_load(f3, res[1:0], rdata) : res;
    sb_q.push_back(e);
    offer(is_load, rd, res, f3, ok);
    if (!ok) return;
    if (!is_load) begin
      @(negedge clk);
      chk("alu_latency_done", 32'(wb_done), 32'd1);
    end else begin
      repeat (delay) begin
        @(negedge clk);
        chk("wait_pend_valid", 32'(pend_valid), 32'd1);
        chk("wait_pend_rd", 32'(pend_rd), 32'(rd));
        chk("wait_no_done", 32'(wb_done), 32'd0);
        @(posedge clk); #1;
      end
      lsu_rvalid = 1'b1;
      lsu_rdata  = rdata;
      @(posedge clk); #1;
      lsu_rvalid = 1'b0;
      lsu_rdata  = $urandom;
      @(negedge clk);
      chk("load_latency_done", 32'(wb_done), 32'd1);
    end
    @(negedge clk);
    chk("ready_after_commit", 32'(exu_ready), 32'd1);
    chk("idle_pend_valid", 32'(pend_valid), 32'd0);
  endtask

  task automatic stray_pulse();
    @(posedge clk); #1;
    lsu_rvalid = 1'b1;
    lsu_rdata  = $urandom;
    @(posedge clk); #1;
    lsu_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_no_wen", 32'(rf_wen), 32'd0);
    chk("stray_no_done", 32'(wb_done), 32'd0);
    chk("stray_ready", 32'(exu_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(exu_ready), 32'd1);
    chk({tag, "_wen"}, 32'(rf_wen), 32'd0);
    chk({tag, "_done"}, 32'(wb_done), 32'd0);
    chk({tag, "_pend"}, 32'(pend_valid), 32'd0);
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_pend_rd"}, 32'(pend_rd), 32'd0);
`ifdef YSYX_23060184_WB_TIMEOUT_EN
    chk({tag, "_err"}, 32'(wb_err), 32'd0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [8];
    logic       ok;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1'b1; exu_valid = 1'b0; exu_rd = '0; exu_result = '0;
    exu_is_load = 1'b0; exu_funct3 = '0; lsu_rvalid = 1'b0; lsu_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed cases.
    txn(1'b0, 5'd5, 32'h0000_1234, 3'd0, 32'h0, 0);
    txn(1'b1, 5'd3, 32'h0000_1002, 3'd0, 32'h0080_0000, 2);
    txn(1'b0, 5'd0, 32'h0000_DEAD, 3'd0, 32'h0, 0);
    txn(1'b1, 5'd7, 32'h0000_2000, 3'd2, 32'hCAFE_F00D, 3);
    stray_pulse();

    // Reset during WAIT_LOAD abandons the load.
    offer(1'b1, 5'd11, 32'h0000_3001, 3'd2, ok);
    @(negedge clk);
    chk("abort_pend_valid", 32'(pend_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_load_reset");
    stray_pulse();

    // Randomized traffic with stray pulses between transactions.
    for (int i = 0; i < 200; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      txn(1'($urandom), rd, $urandom, f3_tab[$urandom_range(0, 7)], $urandom,
          int'($urandom_range(0, 4)));
      if ($urandom_range(0, 5) == 0) stray_pulse();
    end

`ifdef YSYX_23060184_WB_TIMEOUT_EN
    offer(1'b1, 5'd9, 32'h0000_4000, 3'd2, ok);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("timeout_err", 32'(wb_err), 32'd1);
    chk("timeout_ready", 32'(exu_ready), 32'd1);
    chk("timeout_pend", 32'(pend_valid), 32'd0);
    txn(1'b0, 5'd12, 32'h0000_5555, 3'd0, 32'h0, 0);
    chk("timeout_err_sticky", 32'(wb_err), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("timeout_reset");
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_wbu.md
YSYX_23060184_WBU -- requirements
Module: ysyx_23060184_WBU

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5: register index width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: datapath width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port exu_valid, input, 1 bit: the execute stage presents a result.
REQ-006 The block SHALL have port exu_ready, output, 1 bit: the block accepts a result this cycle.
REQ-007 The block SHALL have port exu_rd, input, ADDR_WIDTH bits: destination register.
REQ-008 The block SHALL have port exu_result, input, DATA_WIDTH bits: ALU result, or load address when exu_is_load is 1.
REQ-009 The block SHALL have port exu_is_load, input, 1 bit: the result comes from memory.
REQ-010 The block SHALL have port exu_funct3, input, 3 bits: load type.
REQ-011 The block SHALL have port lsu_rvalid, input, 1 bit: load data valid, single-cycle pulse.
REQ-012 The block SHALL have port lsu_rdata, input, DATA_WIDTH bits: raw aligned memory word.
REQ-013 The block SHALL have port rf_wen, output, 1 bit: register file write strobe.
REQ-014 The block SHALL have port rf_waddr, output, ADDR_WIDTH bits: register file write address.
REQ-015 The block SHALL have port rf_wdata, output, DATA_WIDTH bits: register file write data.
REQ-016 The block SHALL have port wb_done, output, 1 bit: one-cycle retire pulse for commit and difftest.
REQ-017 The block SHALL have port pend_valid, output, 1 bit: a write is in flight.
REQ-018 The block SHALL have port pend_rd, output, ADDR_WIDTH bits: destination of the in-flight write, for hazard checks.
REQ-019 The block SHALL have port wb_err, output, 1 bit: sticky load-timeout flag; it exists only when the timeout feature is compiled in.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_LOAD and COMMIT.
REQ-021 exu_ready SHALL be 1 only in IDLE; a result is accepted when exu_valid and exu_ready are both 1.
REQ-022 On accept, the FSM SHALL go from IDLE to COMMIT if exu_is_load is 0, or to WAIT_LOAD if it is 1, latching rd, result, funct3 and the address bits [1:0].
REQ-023 In WAIT_LOAD, lsu_rvalid SHALL latch the extended load data and move the FSM to COMMIT; while lsu_rvalid is 0 the FSM SHALL stay in WAIT_LOAD.
REQ-024 COMMIT SHALL last exactly one cycle, assert wb_done, assert rf_wen only when the latched rd is not 0, and return to IDLE.
REQ-025 Latency SHALL be 1 cycle from accept to the COMMIT cycle for an ALU result, and 1 cycle from the lsu_rvalid cycle to COMMIT for a load.
REQ-026 Load extension by funct3: 000 (LB) sign-extends the byte at offset addr[1:0]; 001 (LH) sign-extends the halfword at addr[1]; 010 (LW) passes the word; 100 (LBU) and 101 (LHU) zero-extend; any other funct3 is treated as LW.
REQ-027 rf_waddr and rf_wdata SHALL hold their latched values; they are meaningful only while rf_wen is 1.
REQ-028 pend_valid SHALL be 1 in WAIT_LOAD and in COMMIT, with pend_rd equal to the latched rd; pend_valid SHALL be 0 in COMMIT when rd is 0.
REQ-029 lsu_rvalid in IDLE or in COMMIT SHALL be ignored, with no state change.
REQ-030 exu_valid while not ready SHALL be held by the producer; the block drops nothing and duplicates nothing.

Reset
REQ-031 rst SHALL force the FSM to IDLE on the next edge from any state, and any in-flight load SHALL be abandoned without a write.
REQ-032 While in reset and after reset, the outputs SHALL be: exu_ready 1 (after reset), rf_wen 0, wb_done 0, pend_valid 0, rf_waddr 0, rf_wdata 0, pend_rd 0, wb_err 0.

Configuration
REQ-033 With macro YSYX_23060184_WB_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_LOAD and clear on entry to WAIT_LOAD.
REQ-034 When that counter reaches 0xFFFF, the block SHALL set wb_err, return to IDLE with no write and no wb_done, and keep wb_err set until rst.
REQ-035 Without the macro, the block SHALL have no counter and no wb_err port, and WAIT_LOAD SHALL wait indefinitely.

Structure
REQ-036 Package ysyx_23060184_pkg SHALL hold the FSM state enum, the funct3 load constants (LB, LH, LW, LBU, LHU) and the timeout limit constant.
REQ-037 The load extender SHALL be a purely combinational sub-module named ysyx_23060184_LoadExt, with inputs funct3, offset and word and output ext.

Verification
REQ-038 ALU write: accept rd=5, result=0x1234 -> next cycle rf_wen=1, waddr=5, wdata=0x1234 and wb_done=1; one cycle after that, exu_ready=1.
REQ-039 Load byte: accept rd=3, is_load=1, funct3=000, addr[1:0]=2, then lsu_rdata=0x00800000 -> the cycle after rvalid, wdata=0xFFFFFF80.
REQ-040 rd=0: an ALU result of 0xDEAD to rd 0 -> wb_done=1, rf_wen=0, pend_valid=0 throughout.
REQ-041 Hazard and stray pulses: during WAIT_LOAD for rd=7 -> pend_valid=1 and pend_rd=7; an lsu_rvalid pulse while in IDLE -> no write.
REQ-042 Reset mid-load: rst asserted in WAIT_LOAD, then a late lsu_rvalid -> no rf_wen; exu_ready=1 after reset.
REQ-043 Timeout (macro defined): no rvalid for 65535 cycles -> wb_err=1, FSM in IDLE, no wb_done; wb_err stays set until rst.
